// File: rtl/crossbar_rr_arbiter.sv
// Per-slave round-robin grant generator for the N x N request/ack crossbar.
// Each slave runs an IDLE/GRANTED FSM; a grant holds until session finish or watchdog expiry.
module crossbar_rr_arbiter #(
    parameter int unsigned QTY_OF_DEVICES = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [QTY_OF_DEVICES-1:0]                        master_req,
    input  logic [QTY_OF_DEVICES-1:0][ADDR_WIDTH-1:0]        master_addr,
    input  logic [QTY_OF_DEVICES-1:0]                        session_is_finished,
    output logic [QTY_OF_DEVICES-1:0][QTY_OF_DEVICES-1:0]    granted_matrix,
    output logic [QTY_OF_DEVICES-1:0][QTY_OF_DEVICES-1:0]    master_grant,
    output logic [QTY_OF_DEVICES-1:0]                        slave_busy,
    output logic [QTY_OF_DEVICES-1:0]                        timeout_err
);

    localparam int unsigned N     = QTY_OF_DEVICES;
    localparam int unsigned SEL_W = $clog2(N);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                      state_q [N];
    state_t                      state_d [N];
    logic [N-1:0][N-1:0]         grant_q, grant_d;
    logic [N-1:0][SEL_W-1:0]     ptr_q, ptr_d;
    logic [N-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [N-1:0]                tout_q, tout_d;

    logic [N-1:0]                holds;
    logic [N-1:0]                taken;
    logic [N-1:0]                req_s;
    logic                        found;
    logic [SEL_W-1:0]            idx;
    logic [SEL_W-1:0]            pick;

    // State registers for all slave FSMs, pointers, watchdogs and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < N; s++) begin
                state_q[s] <= IDLE;
                ptr_q[s]   <= SEL_W'(N - 1);
            end
            grant_q <= '0;
            cnt_q   <= '0;
            tout_q  <= '0;
        end else begin
            for (int unsigned s = 0; s < N; s++) begin
                state_q[s] <= state_d[s];
            end
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    // Next-state: per-slave arbitration, lower slave index claims a contested master first
    always_comb begin
        for (int unsigned s = 0; s < N; s++) begin
            state_d[s] = state_q[s];
        end
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tout_d  = '0;
        holds   = '0;
        taken   = '0;
        req_s   = '0;
        found   = 1'b0;
        idx     = '0;
        pick    = '0;

        for (int unsigned s = 0; s < N; s++) begin
            for (int unsigned m = 0; m < N; m++) begin
                holds[m] = holds[m] | grant_q[s][m];
            end
        end

        for (int unsigned s = 0; s < N; s++) begin
            for (int unsigned m = 0; m < N; m++) begin
                req_s[m] = master_req[m] & ~holds[m] & ~taken[m] &
                           (master_addr[m][ADDR_WIDTH-1 -: SEL_W] == SEL_W'(s));
            end
            found = 1'b0;
            pick  = '0;
            case (state_q[s])
                IDLE: begin
                    for (int unsigned i = 1; i <= N; i++) begin
                        idx = ptr_q[s] + SEL_W'(i);
                        if (!found && req_s[idx]) begin
                            found = 1'b1;
                            pick  = idx;
                        end
                    end
                    if (found) begin
                        grant_d[s]       = '0;
                        grant_d[s][pick] = 1'b1;
                        ptr_d[s]         = pick;
                        cnt_d[s]         = '0;
                        taken[pick]      = 1'b1;
                        state_d[s]       = GRANTED;
                    end
                end
                GRANTED: begin
                    if (session_is_finished[s]) begin
                        grant_d[s] = '0;
                        state_d[s] = IDLE;
                    end else if ((TIMEOUT_CYCLES != 0) &&
                                 (cnt_q[s] == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                        grant_d[s] = '0;
                        tout_d[s]  = 1'b1;
                        state_d[s] = IDLE;
                    end else begin
                        cnt_d[s] = cnt_q[s] + CNT_W'(1);
                    end
                end
                default: state_d[s] = IDLE;
            endcase
        end
    end

    // Finish pulse masks the grant in the same cycle so the datapath never sees a stale grant
    always_comb begin
        granted_matrix = '0;
        master_grant   = '0;
        slave_busy     = '0;
        for (int unsigned s = 0; s < N; s++) begin
            granted_matrix[s] = grant_q[s] & ~{N{session_is_finished[s]}};
            slave_busy[s]     = (state_q[s] == GRANTED) & ~session_is_finished[s];
            for (int unsigned m = 0; m < N; m++) begin
                master_grant[m][s] = granted_matrix[s][m];
            end
        end
    end

    assign timeout_err = tout_q;

endmodule
